// File: rtl/bn_param_fetch_ctrl_if.sv
// Handshake and data bundle between the BN parameter fetch controller, the two
// parameter ROMs and the BN datapath.
interface bn_param_fetch_ctrl_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int OUT_CHANNELS = 64
);
    localparam int CH_W = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

    logic                         layer_start;
    logic                         rom_rst_n;
    logic                         rom_en;
    logic        [DATA_WIDTH-1:0] mv_a_in;
    logic        [DATA_WIDTH-1:0] mv_b_in;
    logic        [DATA_WIDTH-1:0] gb_a_in;
    logic        [DATA_WIDTH-1:0] gb_b_in;
    logic                         prm_valid;
    logic                         prm_ready;
    logic signed [DATA_WIDTH-1:0] prm_mean;
    logic signed [DATA_WIDTH-1:0] prm_std;
    logic signed [DATA_WIDTH-1:0] prm_gamma;
    logic signed [DATA_WIDTH-1:0] prm_beta;
    logic        [CH_W-1:0]       prm_ch;
    logic                         prm_last_ch;
    logic                         busy;
    logic                         layer_done;

    modport master (
        input  layer_start, mv_a_in, mv_b_in, gb_a_in, gb_b_in, prm_ready,
        output rom_rst_n, rom_en, prm_valid, prm_mean, prm_std, prm_gamma, prm_beta,
               prm_ch, prm_last_ch, busy, layer_done
    );

    modport slave (
        output layer_start, mv_a_in, mv_b_in, gb_a_in, gb_b_in, prm_ready,
        input  rom_rst_n, rom_en, prm_valid, prm_mean, prm_std, prm_gamma, prm_beta,
               prm_ch, prm_last_ch, busy, layer_done
    );
endinterface

// File: rtl/bn_param_fetch_ctrl.sv
// Sequences the mean/std and gamma/beta BN parameter ROMs and streams one
// {mean,std,gamma,beta} bundle per output channel through a 2-entry FIFO.
module bn_param_fetch_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int OUT_CHANNELS = 64,
    parameter int PIXELS       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    bn_param_fetch_ctrl_if.master bus
);
    localparam int TOTAL = OUT_CHANNELS * PIXELS;
    localparam int ISS_W = $clog2(TOTAL + 1);
    localparam int CH_W  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] mean;
        logic signed [DATA_WIDTH-1:0] std;
        logic signed [DATA_WIDTH-1:0] gamma;
        logic signed [DATA_WIDTH-1:0] beta;
    } bundle_t;

    state_t           state;
    logic             rom_rst_n_q;
    logic             busy_q;
    logic             layer_done_q;
    logic             inflight;
    logic [ISS_W-1:0] issued;
    logic [CH_W-1:0]  ch_q;
    logic [PIX_W-1:0] pix_q;

    bundle_t          fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_count;

    logic             valid;
    logic             pop;
    logic             head_last;
    logic             last_pop;
    logic             fetch;
    logic [2:0]       occupancy;
    bundle_t          head;

    assign valid     = (fifo_count != 2'd0);
    assign pop       = valid & bus.prm_ready;
    assign head_last = (ch_q == CH_W'(OUT_CHANNELS - 1));
    assign last_pop  = pop & head_last & (pix_q == PIX_W'(PIXELS - 1));
    assign head      = fifo_mem[rd_ptr];

    // Occupancy counts bundles already queued plus the one arriving from the ROMs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
        fetch     = 1'b0;
        if (state == RUN && issued < ISS_W'(TOTAL) && occupancy < 3'd2) begin
            fetch = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rom_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            inflight     <= 1'b0;
            issued       <= '0;
            ch_q         <= '0;
            pix_q        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            layer_done_q <= 1'b0;
            inflight     <= fetch;
            if (fetch) begin
                issued <= issued + 1'b1;
            end
            if (pop) begin
                ch_q <= head_last ? '0 : ch_q + 1'b1;
                if (head_last) begin
                    pix_q <= (pix_q == PIX_W'(PIXELS - 1)) ? '0 : pix_q + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    // A start coinciding with layer_done is dropped on purpose.
                    if (bus.layer_start && !layer_done_q) begin
                        state       <= RUN;
                        rom_rst_n_q <= 1'b1;
                        busy_q      <= 1'b1;
                        issued      <= '0;
                    end
                end
                RUN: begin
                    if (last_pop) begin
                        state        <= IDLE;
                        rom_rst_n_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        layer_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two FIFO entries are reset so the head outputs read zero
            // out of reset; larger storage arrays would normally be left unreset.
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= {bus.mv_a_in, bus.mv_b_in, bus.gb_a_in, bus.gb_b_in};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(inflight) - 2'(pop);
        end
    end

    assign bus.rom_rst_n   = rom_rst_n_q;
    assign bus.rom_en      = fetch;
    assign bus.prm_valid   = valid;
    assign bus.prm_mean    = head.mean;
    assign bus.prm_std     = head.std;
    assign bus.prm_gamma   = head.gamma;
    assign bus.prm_beta    = head.beta;
    assign bus.prm_ch      = ch_q;
    assign bus.prm_last_ch = valid & head_last;
    assign bus.busy        = busy_q;
    assign bus.layer_done  = layer_done_q;
endmodule

// File: tb/tb_bn_param_fetch_ctrl.sv
// Bench for bn_param_fetch_ctrl: behavioural dual-port ROMs plus a reference
// model that predicts the k-th accepted bundle of a layer from ROM contents.
module tb_bn_param_fetch_ctrl;
    localparam int DW = 16;
    localparam int OC = 4;
    localparam int PX = 2;
    localparam int N  = OC * PX;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bn_param_fetch_ctrl_if #(.DATA_WIDTH(DW), .OUT_CHANNELS(OC)) bus ();

    bn_param_fetch_ctrl #(.DATA_WIDTH(DW), .OUT_CHANNELS(OC), .PIXELS(PX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Two ROMs, each 2*OC words: port A reads base 0, port B reads base OC.
    logic [DW-1:0] mv_mem [2*OC];
    logic [DW-1:0] gb_mem [2*OC];
    int            rom_ptr;

    always @(posedge clk) begin
        if (!bus.rom_rst_n) begin
            rom_ptr <= 0;
        end else if (bus.rom_en) begin
            bus.mv_a_in <= mv_mem[rom_ptr];
            bus.mv_b_in <= mv_mem[rom_ptr + OC];
            bus.gb_a_in <= gb_mem[rom_ptr];
            bus.gb_b_in <= gb_mem[rom_ptr + OC];
            rom_ptr     <= (rom_ptr + 1) % OC;
        end
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pop_idx, fetch_total, pop_total, layer_fetch, layer_pops, en_count;
    int          first_pop_cyc, last_pop_cyc;
    bit          prev_stall, prev_final;
    logic [66:0] prev_head, first_head;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] head_vec();
        return {bus.prm_mean, bus.prm_std, bus.prm_gamma, bus.prm_beta,
                bus.prm_ch, bus.prm_last_ch};
    endfunction

    // Reference: the k-th bundle of a layer belongs to channel k mod OC.
    function automatic logic [66:0] exp_vec(input int k);
        int c;
        c = k % OC;
        return {mv_mem[c], mv_mem[OC + c], gb_mem[c], gb_mem[OC + c], 2'(c), 1'(c == OC - 1)};
    endfunction

    task automatic reset_model();
        pop_idx     = 0;
        fetch_total = 0;
        pop_total   = 0;
        prev_stall  = 0;
        prev_final  = 0;
    endtask

    // One clock: drive at edge+1, observe at the falling edge, then advance.
    task automatic tick(input bit ready, input bit start, input bit rst_v);
        bit pop;
        bus.prm_ready   = ready;
        bus.layer_start = start;
        rst             = rst_v;
        @(negedge clk);
        pop = bus.prm_valid & ready;
        if (rst_v) begin
            reset_model();
        end else begin
            check("layer_done", 128'(bus.layer_done), 128'(prev_final));
            if (prev_stall) begin
                check("stall_hold", 128'({bus.prm_valid, head_vec()}), 128'({1'b1, prev_head}));
            end
            if (bus.rom_en) begin
                check("no_overfill", 128'((fetch_total - pop_total - int'(pop)) < 2), 128'(1));
                fetch_total++;
                layer_fetch++;
                en_count++;
            end
            prev_final = 0;
            if (pop) begin
                check("bundle", 128'(head_vec()), 128'(exp_vec(pop_idx)));
                if (first_pop_cyc < 0) begin
                    first_pop_cyc = cyc;
                    first_head    = head_vec();
                end
                last_pop_cyc = cyc;
                pop_total++;
                layer_pops++;
                if (pop_idx == N - 1) begin
                    prev_final = 1;
                    pop_idx    = 0;
                end else begin
                    pop_idx++;
                end
            end
            prev_stall = bus.prm_valid & ~ready;
            prev_head  = head_vec();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_layer(input bit ready);
        layer_fetch   = 0;
        layer_pops    = 0;
        first_pop_cyc = -1;
        tick(ready, 1'b1, 1'b0);
    endtask

    task automatic drain(input string tag, input bit rnd, input bit start_on_done);
        int n;
        n = 0;
        while (!prev_final && n < 200) begin
            tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
            n++;
        end
        check({tag, "_final_pop"}, 128'(prev_final), 128'(1));
        tick(1'b1, start_on_done, 1'b0);
        check({tag, "_pops"}, 128'(layer_pops), 128'(N));
        check({tag, "_fetches"}, 128'(layer_fetch), 128'(N));
    endtask

    initial begin
        for (int i = 0; i < OC; i++) begin
            mv_mem[i]      = DW'(i);
            mv_mem[OC + i] = DW'($urandom);
            gb_mem[i]      = DW'($urandom);
            gb_mem[OC + i] = DW'($urandom);
        end
        en_count        = 0;
        bus.prm_ready   = 1'b0;
        bus.layer_start = 1'b0;
        rst             = 1'b1;
        reset_model();
        @(posedge clk);
        #1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("rst_rom_rst_n", 128'(bus.rom_rst_n), 128'(0));
        check("rst_rom_en", 128'(bus.rom_en), 128'(0));
        check("rst_valid", 128'(bus.prm_valid), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_layer_done", 128'(bus.layer_done), 128'(0));
        check("rst_data", 128'({bus.prm_mean, bus.prm_std, bus.prm_gamma, bus.prm_beta}), 128'(0));
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Streaming layer with prm_ready held high.
        start_layer(1'b1);
        check("run_busy", 128'(bus.busy), 128'(1));
        check("run_rom_rst_n", 128'(bus.rom_rst_n), 128'(1));
        check("run_first_fetch", 128'(bus.rom_en), 128'(1));
        drain("stream", 1'b0, 1'b0);
        check("stream_back_to_back", 128'(last_pop_cyc - first_pop_cyc), 128'(N - 1));
        tick(1'b0, 1'b0, 1'b0);
        check("idle_busy", 128'(bus.busy), 128'(0));
        check("idle_rom_rst_n", 128'(bus.rom_rst_n), 128'(0));

        // Datapath stalled for 10 cycles, then random backpressure.
        start_layer(1'b0);
        repeat (9) tick(1'b0, 1'b0, 1'b0);
        check("stall_fetches", 128'(layer_fetch), 128'(2));
        check("stall_valid", 128'(bus.prm_valid), 128'(1));
        check("stall_ch", 128'(bus.prm_ch), 128'(0));
        drain("random", 1'b1, 1'b0);

        // Reset mid-layer after five bundles, then restart from base.
        start_layer(1'b1);
        for (int n = 0; n < 50 && layer_pops < 5; n++) tick(1'b1, 1'b0, 1'b0);
        check("midrst_pops", 128'(layer_pops), 128'(5));
        tick(1'b1, 1'b0, 1'b1);
        check("midrst_valid", 128'(bus.prm_valid), 128'(0));
        check("midrst_busy", 128'(bus.busy), 128'(0));
        check("midrst_rom_rst_n", 128'(bus.rom_rst_n), 128'(0));
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        start_layer(1'b1);
        drain("restart", 1'b0, 1'b0);
        check("restart_base", 128'(first_head[66:3]),
              128'({mv_mem[0], mv_mem[OC], gb_mem[0], gb_mem[OC]}));

        // Back-to-back layers; start pulses during RUN and with layer_done are dropped.
        en_count = 0;
        start_layer(1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        drain("b2b_first", 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("done_start_ignored", 128'(bus.busy), 128'(0));
        start_layer(1'b1);
        drain("b2b_second", 1'b1, 1'b0);
        check("b2b_total_fetches", 128'(en_count), 128'(2 * N));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
